window_pack: RTL and testbench

WINDOW_PACK -- requirements
Module: window_pack

---
 rtl/window_pack.sv | 62 ++++++
 tb/tb_window_pack.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/window_pack.sv
// Sliding-window serial-to-parallel packer. Lane 0 holds the newest sample. Once the
// window is full, a vector is emitted every STRIDE accepted samples.
module window_pack #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned SIZE   = 3,
   parameter int unsigned STRIDE = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic [WIDTH-1:0]      i_tdata,
   input  logic                  i_tvalid,
   output logic                  i_tready,
   output logic [SIZE*WIDTH-1:0] o_tdata,
   output logic                  o_tvalid,
   input  logic                  o_tready
);

   localparam int unsigned FW = $clog2(SIZE + 1);
   localparam int unsigned PW = $clog2(STRIDE + 1);
   localparam logic [FW-1:0] FULL   = FW'(SIZE);
   localparam logic [FW-1:0] ALMOST = FW'(SIZE - 1);
   localparam logic [PW-1:0] LAST   = PW'(STRIDE - 1);

   logic [SIZE*WIDTH-1:0] win;
   logic [FW-1:0]         fill;
   logic [PW-1:0]         phase;
   logic                  accept;
   logic                  emit;

   always_comb begin
      i_tready = ~o_tvalid | o_tready;
      accept   = i_tvalid & i_tready;
      emit     = accept & ((fill == ALMOST) | ((fill == FULL) & (phase == LAST)));
      o_tdata  = win;
   end

   always_ff @(posedge clk) begin
      if (reset | clear) begin
         win      <= '0;
         fill     <= '0;
         phase    <= '0;
         o_tvalid <= 1'b0;
      end else begin
         if (accept) begin
            win <= {win[(SIZE-1)*WIDTH-1:0], i_tdata};
            if (fill != FULL)
               fill <= fill + FW'(1);
            // Phase only advances once the window is full; the filling sample restarts it.
            if (fill == ALMOST)
               phase <= '0;
            else if (fill == FULL)
               phase <= (phase == LAST) ? '0 : phase + PW'(1);
         end
         if (emit)
            o_tvalid <= 1'b1;
         else if (o_tready)
            o_tvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_window_pack.sv
// Directed bench for window_pack: three configurations share the input stimulus,
// and each scenario checks only the instance it targets.
module tb_window_pack;

   logic        clk = 1'b0;
   logic        reset, clear, i_tvalid, o_tready;
   logic [15:0] din;

   logic        a_tready, a_tvalid;
   logic [47:0] a_tdata;
   logic        b_tready, b_tvalid;
   logic [47:0] b_tdata;
   logic        c_tready, c_tvalid;
   logic [63:0] c_tdata;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   window_pack #(.WIDTH(16), .SIZE(3), .STRIDE(1)) dut_a (
      .clk(clk), .reset(reset), .clear(clear), .i_tdata(din), .i_tvalid(i_tvalid),
      .i_tready(a_tready), .o_tdata(a_tdata), .o_tvalid(a_tvalid), .o_tready(o_tready));

   window_pack #(.WIDTH(16), .SIZE(3), .STRIDE(3)) dut_b (
      .clk(clk), .reset(reset), .clear(clear), .i_tdata(din), .i_tvalid(i_tvalid),
      .i_tready(b_tready), .o_tdata(b_tdata), .o_tvalid(b_tvalid), .o_tready(o_tready));

   window_pack #(.WIDTH(16), .SIZE(4), .STRIDE(2)) dut_c (
      .clk(clk), .reset(reset), .clear(clear), .i_tdata(din), .i_tvalid(i_tvalid),
      .i_tready(c_tready), .o_tdata(c_tdata), .o_tvalid(c_tvalid), .o_tready(o_tready));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are read just after it.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; clear = 1'b0; i_tvalid = 1'b0; o_tready = 1'b1; din = '0;
      step();
      reset = 1'b0;
   endtask

   task automatic push(input logic [15:0] v);
      din = v; i_tvalid = 1'b1;
      step();
   endtask

   logic [63:0] vecs [$];
   int unsigned idx;
   logic [15:0] lane0_exp [4] = '{16'd4, 16'd6, 16'd8, 16'd10};

   initial begin
      reset = 1'b1; clear = 1'b0; i_tvalid = 1'b0; o_tready = 1'b1; din = '0;
      @(negedge clk);
      do_reset();

      // Reset state
      check("rst_valid", 64'(a_tvalid), 64'd0);
      check("rst_data", 64'(a_tdata), 64'd0);
      check("rst_ready", 64'(a_tready), 64'd1);

      // Back-to-back samples, stride 1
      push(16'd1); check("s1_v1", 64'(a_tvalid), 64'd0);
      push(16'd2); check("s1_v2", 64'(a_tvalid), 64'd0);
      push(16'd3); check("s1_v3", 64'(a_tvalid), 64'd1);
      check("s1_d3", 64'(a_tdata), 64'h0001_0002_0003);
      push(16'd4); check("s1_v4", 64'(a_tvalid), 64'd1);
      check("s1_d4", 64'(a_tdata), 64'h0002_0003_0004);
      i_tvalid = 1'b0; step();
      check("s1_drop", 64'(a_tvalid), 64'd0);

      // Non-overlapping packing, stride 3
      do_reset();
      vecs.delete();
      for (int i = 1; i <= 6; i++) begin
         push(16'(i));
         if (b_tvalid) vecs.push_back(64'(b_tdata));
      end
      i_tvalid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (b_tvalid) vecs.push_back(64'(b_tdata));
      end
      check("s3_count", 64'(vecs.size()), 64'd2);
      if (vecs.size() >= 2) begin
         check("s3_vec0", vecs[0], 64'h0001_0002_0003);
         check("s3_vec1", vecs[1], 64'h0004_0005_0006);
      end

      // Backpressure holds the window
      do_reset();
      push(16'd1); push(16'd2); push(16'd3);
      o_tready = 1'b0; din = 16'd4; i_tvalid = 1'b1; #1;
      check("bp_ready0", 64'(a_tready), 64'd0);
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_hold_d", 64'(a_tdata), 64'h0001_0002_0003);
         check("bp_hold_v", 64'(a_tvalid), 64'd1);
      end
      o_tready = 1'b1; #1;
      check("bp_ready1", 64'(a_tready), 64'd1);
      step();
      check("bp_next_v", 64'(a_tvalid), 64'd1);
      check("bp_next_d", 64'(a_tdata), 64'h0002_0003_0004);
      i_tvalid = 1'b0; step();
      check("bp_drop", 64'(a_tvalid), 64'd0);

      // Clear mid-fill drops the partial window and the sample presented with it
      do_reset();
      push(16'd7); check("clr_v7", 64'(a_tvalid), 64'd0);
      push(16'd8); check("clr_v8", 64'(a_tvalid), 64'd0);
      clear = 1'b1; din = 16'd9; i_tvalid = 1'b1;
      step();
      clear = 1'b0;
      check("clr_data", 64'(a_tdata), 64'd0);
      push(16'd1); check("clr_v1", 64'(a_tvalid), 64'd0);
      push(16'd2); check("clr_v2", 64'(a_tvalid), 64'd0);
      push(16'd3); check("clr_v3", 64'(a_tvalid), 64'd1);
      check("clr_d3", 64'(a_tdata), 64'h0001_0002_0003);
      i_tvalid = 1'b0; step();
      check("clr_end", 64'(a_tvalid), 64'd0);

      // Reset discards a held vector
      do_reset();
      push(16'd1); push(16'd2); push(16'd3);
      i_tvalid = 1'b0; o_tready = 1'b0;
      step();
      check("rh_held", 64'(a_tvalid), 64'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rh_valid", 64'(a_tvalid), 64'd0);
      check("rh_data", 64'(a_tdata), 64'd0);
      check("rh_ready", 64'(a_tready), 64'd1);

      // Random handshakes, size 4, stride 2
      do_reset();
      vecs.delete();
      idx = 1;
      for (int cyc = 0; cyc < 500 && vecs.size() < 4; cyc++) begin
         o_tready = 1'($urandom_range(0, 1));
         i_tvalid = (idx <= 10) ? 1'($urandom_range(0, 1)) : 1'b0;
         din = 16'(idx);
         #1;
         if (c_tvalid && o_tready) vecs.push_back(c_tdata);
         if (i_tvalid && c_tready) idx++;
         step();
      end
      i_tvalid = 1'b0; o_tready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (c_tvalid) vecs.push_back(c_tdata);
         step();
      end
      check("rnd_count", 64'(vecs.size()), 64'd4);
      if (vecs.size() >= 1)
         check("rnd_first", vecs[0], 64'h0001_0002_0003_0004);
      for (int i = 0; i < 4 && i < vecs.size(); i++)
         check($sformatf("rnd_lane0_%0d", i), 64'(vecs[i][15:0]), 64'(lane0_exp[i]));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
